// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package inst_loader_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned COUNT_W         = 16;
    localparam int unsigned WORD_ADDR_SHIFT = 2;

    // Frame words arrive least-significant byte first.
    localparam bit FRAME_LSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        FIN  = 3'd4,
        RUN  = 3'd5,
        ERRS = 3'd6
    } state_t;

endpackage

// File: rtl/inst_loader_pack.sv
// Byte-to-word packer: collects four stream bytes and flags the completing byte.
module inst_loader_pack
    import inst_loader_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_en,
    output logic [WORD_W-1:0] word_c,
    output logic              word_valid_c
);

    logic [1:0]             idx_q;
    logic [WORD_W-BYTE_W-1:0] shift_q;
    logic [WORD_W-BYTE_W-1:0] shift_d;

    // The completing byte is merged combinationally so the word is usable on its own edge.
    always_comb begin
        if (FRAME_LSB_FIRST) begin
            shift_d = {byte_in, shift_q[WORD_W-BYTE_W-1:BYTE_W]};
            word_c  = {byte_in, shift_q};
        end else begin
            shift_d = {shift_q[WORD_W-2*BYTE_W-1:0], byte_in};
            word_c  = {shift_q, byte_in};
        end
        word_valid_c = byte_en && (idx_q == 2'd3);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx_q   <= 2'd0;
            shift_q <= '0;
        end else if (byte_en) begin
            idx_q   <= idx_q + 2'd1;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Program loader: framed byte stream to instruction-memory writes, holds the CPU until done.
// Optional trailing checksum word enabled by defining INST_LOADER_CSUM_EN.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [BYTE_W-1:0] IN_BYTE,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic              MEM_WE,
    output logic [WORD_W-1:0] MEM_ADDR,
    output logic [WORD_W-1:0] MEM_WDATA,
    output logic              CPU_HOLD,
    output logic              DONE,
    output logic              ERR
);

    state_t               state_q;
    state_t               state_d;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   count_full_c;
    logic [COUNT_W-1:0]   word_idx_q;
    logic                 accept_c;
    logic                 pack_en_c;
    logic [WORD_W-1:0]    word_c;
    logic                 word_valid_c;
`ifdef INST_LOADER_CSUM_EN
    logic [WORD_W-1:0]    csum_q;
`endif

    assign accept_c     = IN_VALID && IN_READY;
    assign count_full_c = {IN_BYTE, count_q[BYTE_W-1:0]};
`ifdef INST_LOADER_CSUM_EN
    assign pack_en_c    = accept_c && ((state_q == DATA) || (state_q == CSUM));
`else
    assign pack_en_c    = accept_c && (state_q == DATA);
`endif

    inst_loader_pack u_pack (
        .CLK          (CLK),
        .RST          (RST),
        .byte_in      (IN_BYTE),
        .byte_en      (pack_en_c),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
    );

    // Frame sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LEN0: if (accept_c) state_d = LEN1;
            LEN1: begin
                if (accept_c) begin
                    if (count_full_c == '0) begin
`ifdef INST_LOADER_CSUM_EN
                        state_d = CSUM;
`else
                        state_d = FIN;
`endif
                    end else if (count_full_c > COUNT_W'(DEPTH_WORDS)) begin
                        state_d = ERRS;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid_c && (word_idx_q == count_q - COUNT_W'(1))) begin
`ifdef INST_LOADER_CSUM_EN
                    state_d = CSUM;
`else
                    state_d = FIN;
`endif
                end
            end
`ifdef INST_LOADER_CSUM_EN
            CSUM: if (word_valid_c) state_d = (word_c == csum_q) ? FIN : ERRS;
`endif
            FIN:  state_d = RUN;
            RUN:  state_d = RUN;
            ERRS: state_d = ERRS;
            default: state_d = ERRS;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= LEN0;
            IN_READY <= 1'b1;
            CPU_HOLD <= 1'b1;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state_q  <= state_d;
            IN_READY <= (state_d == LEN0) || (state_d == LEN1) ||
                        (state_d == DATA) || (state_d == CSUM);
            CPU_HOLD <= (state_d != RUN);
            DONE     <= (state_d == FIN);
            ERR      <= (state_d == ERRS);
        end
    end

    // Length latch, word addressing and memory write port.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q    <= '0;
            word_idx_q <= '0;
            MEM_WE     <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_WDATA  <= '0;
`ifdef INST_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            MEM_WE <= 1'b0;
            if (accept_c && (state_q == LEN0)) count_q[BYTE_W-1:0] <= IN_BYTE;
            if (accept_c && (state_q == LEN1)) count_q[COUNT_W-1:BYTE_W] <= IN_BYTE;
            if ((state_q == DATA) && word_valid_c) begin
                MEM_WE     <= 1'b1;
                MEM_ADDR   <= WORD_W'(word_idx_q) << WORD_ADDR_SHIFT;
                MEM_WDATA  <= word_c;
                word_idx_q <= word_idx_q + COUNT_W'(1);
`ifdef INST_LOADER_CSUM_EN
                csum_q     <= csum_q + word_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader against a frame-level reference model.
module tb_inst_loader;

    localparam int unsigned DEPTH = 64;
`ifdef INST_LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  IN_BYTE = 8'h00;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERR;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] words_q[$];
    logic [31:0] exp_addr  = 32'h0;
    logic [31:0] exp_wdata = 32'h0;

    inst_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_BYTE   (IN_BYTE),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .CPU_HOLD  (CPU_HOLD),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        RST      = 1'b0;
        IN_VALID = 1'b0;
        #1;
        check("rst_in_ready",  32'(IN_READY),  32'd1);
        check("rst_mem_we",    32'(MEM_WE),    32'd0);
        check("rst_mem_addr",  MEM_ADDR,       32'd0);
        check("rst_mem_wdata", MEM_WDATA,      32'd0);
        check("rst_cpu_hold",  32'(CPU_HOLD),  32'd1);
        check("rst_done",      32'(DONE),      32'd0);
        check("rst_err",       32'(ERR),       32'd0);
        @(negedge CLK);
        RST       = 1'b1;
        exp_addr  = 32'h0;
        exp_wdata = 32'h0;
    endtask

    // Sends one frame built from words_q; abort_after >= 0 resets after that many accepted bytes.
    task automatic run_frame(input int cnt, input bit bad_csum, input int gap, input int abort_after);
        logic [7:0]  frame[$];
        logic [31:0] sum;
        logic [31:0] csum;
        bit          len_ok;
        bit          ok;
        int          n;
        int          pos;
        int          cyc;
        int          budget;
        int          apos;
        int          cnt_eff;
        bit          v;
        bit          we_exp;

        frame.delete();
        frame.push_back(8'(cnt));
        frame.push_back(8'(cnt >> 8));
        len_ok = (cnt <= DEPTH);
        sum    = 32'h0;
        if (len_ok) begin
            for (int w = 0; w < cnt; w++) begin
                for (int b = 0; b < 4; b++) frame.push_back(8'(words_q[w] >> (8 * b)));
                sum = sum + words_q[w];
            end
            if (CSUM_ON) begin
                csum = bad_csum ? sum + 32'(1 + $urandom_range(0, 1000)) : sum;
                for (int b = 0; b < 4; b++) frame.push_back(8'(csum >> (8 * b)));
            end
        end
        ok      = len_ok && !(CSUM_ON && bad_csum);
        n       = frame.size();
        cnt_eff = len_ok ? cnt : 0;
        pos     = 0;
        cyc     = 0;
        budget  = 16 * n + 50;

        forever begin
            check("in_ready", 32'(IN_READY), (pos < n) ? 32'd1 : 32'd0);
            if (pos >= n) break;
            if (abort_after >= 0 && pos == abort_after) begin
                do_reset();
                return;
            end
            if (cyc >= budget) begin
                check("timeout_bytes", 32'(pos), 32'(n));
                IN_VALID = 1'b0;
                return;
            end
            case (gap)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            IN_VALID = v;
            IN_BYTE  = v ? frame[pos] : 8'($urandom);
            apos = -1;
            if (v && IN_READY) begin
                apos = pos;
                pos++;
            end
            @(posedge CLK);
            @(negedge CLK);
            cyc++;
            we_exp = (apos >= 2) && (apos < 2 + 4 * cnt_eff) && (((apos - 2) % 4) == 3);
            if (we_exp) begin
                exp_addr  = 32'(((apos - 2) / 4) * 4);
                exp_wdata = words_q[(apos - 2) / 4];
            end
            check("mem_we",    32'(MEM_WE),   32'(we_exp));
            check("mem_addr",  MEM_ADDR,      exp_addr);
            check("mem_wdata", MEM_WDATA,     exp_wdata);
            check("done",      32'(DONE),     32'(ok && apos == n - 1));
            check("err",       32'(ERR),      32'(!ok && pos == n));
            check("cpu_hold",  32'(CPU_HOLD), 32'd1);
        end

        // Trailing junk must be ignored once the frame has ended.
        for (int t = 0; t < 3; t++) begin
            IN_VALID = 1'b1;
            IN_BYTE  = 8'($urandom);
            @(posedge CLK);
            @(negedge CLK);
            check("tail_in_ready", 32'(IN_READY), 32'd0);
            check("tail_mem_we",   32'(MEM_WE),   32'd0);
            check("tail_mem_addr", MEM_ADDR,      exp_addr);
            check("tail_done",     32'(DONE),     32'd0);
            check("tail_err",      32'(ERR),      32'(!ok));
            check("tail_cpu_hold", 32'(CPU_HOLD), 32'(!ok));
        end
        IN_VALID = 1'b0;
    endtask

    task automatic rand_words(input int cnt);
        words_q.delete();
        for (int i = 0; i < cnt; i++) words_q.push_back(32'($urandom));
    endtask

    initial begin
        int cnt;
        int sel;
        @(negedge CLK);
        do_reset();

        // Two-word program from the bring-up example.
        words_q.delete();
        words_q.push_back(32'h0000_00B3);
        words_q.push_back(32'h4011_0133);
        run_frame(2, 1'b0, 0, -1);
        do_reset();

        // Empty program.
        words_q.delete();
        run_frame(0, 1'b0, 0, -1);
        do_reset();

        // Over-length and exact-capacity counts.
        run_frame(65, 1'b0, 0, -1);
        do_reset();
        rand_words(64);
        run_frame(64, 1'b0, 0, -1);
        do_reset();

        // Bad checksum on a single word.
        words_q.delete();
        words_q.push_back(32'h0000_0013);
        run_frame(1, 1'b1, 0, -1);
        do_reset();

        // Alternating-valid input.
        rand_words(3);
        run_frame(3, 1'b0, 1, -1);
        do_reset();

        // Reset part-way through the second word, then a fresh one-word frame.
        rand_words(2);
        run_frame(2, 1'b0, 0, 8);
        rand_words(1);
        run_frame(1, 1'b0, 0, -1);
        do_reset();

        for (int f = 0; f < 30; f++) begin
            sel = $urandom_range(0, 19);
            if (sel < 2)       cnt = 0;
            else if (sel == 2) cnt = 64;
            else if (sel == 3) cnt = $urandom_range(65, 65535);
            else               cnt = $urandom_range(1, 8);
            rand_words((cnt <= 64) ? cnt : 0);
            run_frame(cnt, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), -1);
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
